// File: rtl/dsc_mul_n.sv
// dsc_mul_n: deterministic stochastic-computing multiplier; N_IN odometer-chained SNG streams ANDed and counted.
// Latency: start accepted at edge t, done pulses in the cycle after edge t+L (L enabled RUN cycles).
// Backpressure: en low freezes all RUN state one-for-one; start is ignored unless the block is IDLE.
module dsc_mul_n #(
  parameter int N_IN       = 4,
  parameter int SNG_W      = 8,
  parameter bit EARLY_STOP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  input  logic [N_IN*SNG_W-1:0]   operands,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN*SNG_W-1:0]   z,
  output logic                    sn_out
);

  localparam int                ZW      = N_IN * SNG_W;
  localparam logic [SNG_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                        state_q, state_d;
  logic [N_IN-1:0][SNG_W-1:0]    op_q, op_d;
  logic [N_IN-1:0][SNG_W-1:0]    cnt_q, cnt_d;
  logic [ZW-1:0]                 z_q, z_d;
  logic [N_IN-1:0]               sng_bit;
  logic [N_IN-1:0]               step;
  logic                          last_cycle;

  // SNG comparators and the odometer carry chain (step[i]: counter i advances this cycle)
  always_comb begin
    sng_bit = '0;
    step    = '0;
    for (int i = 0; i < N_IN; i++) begin
      sng_bit[i] = (cnt_q[i] < op_q[i]);
    end
    step[0] = 1'b1;
    for (int i = 1; i < N_IN; i++) begin
      step[i] = step[i-1] & (cnt_q[i-1] == CNT_MAX);
    end
  end

  // Final enabled RUN cycle: early mode stops once the top stream is exhausted,
  // full mode stops when the whole odometer rolls over.
  always_comb begin
    if (EARLY_STOP) begin
      last_cycle = step[N_IN-1] &
                   (({1'b0, cnt_q[N_IN-1]} + (SNG_W+1)'(1)) == {1'b0, op_q[N_IN-1]});
    end else begin
      last_cycle = step[N_IN-1] & (cnt_q[N_IN-1] == CNT_MAX);
    end
  end

  // Next-state logic for the FSM, operand latch, counters and product count
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    sn_out  = (state_q == RUN) & (&sng_bit);
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < N_IN; i++) begin
            op_d[i] = operands[i*SNG_W +: SNG_W];
          end
          cnt_d = '0;
          z_d   = '0;
          // A zero top operand means an empty run in early mode
          if (EARLY_STOP && (operands[ZW-1 -: SNG_W] == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (en) begin
          z_d = z_q + ZW'(sn_out);
          for (int i = 0; i < N_IN; i++) begin
            if (step[i]) cnt_d[i] = cnt_q[i] + SNG_W'(1);
          end
          if (last_cycle) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign z    = z_q;

endmodule

// File: tb/tb_dsc_mul_n.sv
// tb_dsc_mul_n: directed bench for dsc_mul_n in three parameterisations sharing one clock and reset.
// Latency: each run is checked for exact cycle count, result, sn_out stream and done/busy timing.
// Backpressure: en is dropped mid-run and start is pulsed during busy to confirm both are handled.
module tb_dsc_mul_n;

  logic       clk;
  logic       rst;
  logic       start [3];
  logic       en    [3];
  logic [7:0] ops   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [7:0] z     [3];
  logic       sn    [3];

  int n_cmp = 0;
  int n_err = 0;

  // idx 0: N_IN=2 SNG_W=4 full run; idx 1: same, early stop; idx 2: N_IN=4 SNG_W=2 early stop
  dsc_mul_n #(.N_IN(2), .SNG_W(4), .EARLY_STOP(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start[0]), .en(en[0]), .operands(ops[0]),
    .busy(busy[0]), .done(done[0]), .z(z[0]), .sn_out(sn[0]));

  dsc_mul_n #(.N_IN(2), .SNG_W(4), .EARLY_STOP(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start[1]), .en(en[1]), .operands(ops[1]),
    .busy(busy[1]), .done(done[1]), .z(z[1]), .sn_out(sn[1]));

  dsc_mul_n #(.N_IN(4), .SNG_W(2), .EARLY_STOP(1'b1)) u_quad (
    .clk(clk), .rst(rst), .start(start[2]), .en(en[2]), .operands(ops[2]),
    .busy(busy[2]), .done(done[2]), .z(z[2]), .sn_out(sn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // One transaction on instance idx: accept, track a reference odometer for sn_out
  // each cycle, optionally drop en / poke start mid-run, then check latency and result.
  task automatic run(input int idx, input logic [7:0] opv, input int exp_l, input int exp_z,
                     input int drops, input bit disturb, input bit hold, input string tag);
    int n, w, nn, left, mx;
    int cnt [4];
    int opi [4];
    bit msn, carry;
    nn = (idx == 2) ? 4 : 2;
    w  = (idx == 2) ? 2 : 4;
    mx = (1 << w) - 1;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      opi[i] = (i < nn) ? ((int'(opv) >> (i * w)) & mx) : 0;
    end
    chk({tag, "_idle"}, busy[idx], 0);
    start[idx] = 1'b1;
    ops[idx]   = opv;
    en[idx]    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start[idx] = 1'b0;
    chk({tag, "_zclr"}, z[idx], 0);
    n    = 0;
    left = drops;
    while (!done[idx] && n < exp_l + drops + 50) begin
      msn = 1'b1;
      for (int i = 0; i < nn; i++) if (cnt[i] >= opi[i]) msn = 1'b0;
      chk({tag, "_sn"}, sn[idx], msn);
      en[idx] = 1'b1;
      if (left > 0 && n >= 20 && ($urandom_range(0, 3) == 0 || n >= 200)) begin
        en[idx] = 1'b0;
        left--;
      end
      if (disturb && n == 30) begin
        start[idx] = 1'b1;
        ops[idx]   = 8'hFF;
      end
      if (disturb && n == 31) start[idx] = 1'b0;
      @(posedge clk);
      if (en[idx]) begin
        carry = 1'b1;
        for (int i = 0; i < nn; i++) begin
          if (carry) begin
            if (cnt[i] == mx) cnt[i] = 0;
            else begin
              cnt[i]++;
              carry = 1'b0;
            end
          end
        end
      end
      n++;
      @(negedge clk);
    end
    en[idx] = 1'b1;
    chk({tag, "_lat"}, n, exp_l + drops);
    chk({tag, "_done"}, done[idx], 1);
    chk({tag, "_busy_d"}, busy[idx], 1);
    chk({tag, "_z"}, z[idx], exp_z);
    chk({tag, "_sn_d"}, sn[idx], 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done1"}, done[idx], 0);
    chk({tag, "_busy1"}, busy[idx], 0);
    chk({tag, "_zhold"}, z[idx], exp_z);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      en[i]    = 1'b1;
      ops[i]   = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_z", z[i], 0);
      chk("rst_sn", sn[i], 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Operand byte = {op1, op0} for N_IN=2, {op3, op2, op1, op0} for N_IN=4
    run(0, 8'h35, 256, 15, 0, 1'b0, 1'b0, "full_5x3");
    run(1, 8'h35, 48, 15, 0, 1'b0, 1'b0, "early_5x3");
    run(1, 8'h05, 0, 0, 0, 1'b0, 1'b0, "early_5x0");
    run(2, 8'hFF, 192, 81, 0, 1'b0, 1'b0, "quad_3333");
    run(2, 8'h7F, 64, 27, 0, 1'b0, 1'b0, "quad_3331");
    run(0, 8'h35, 256, 15, 10, 1'b1, 1'b0, "full_en_drop");

    // Asynchronous reset between edges, 35 cycles into a (5,3) run: z=13, sn=1 beforehand
    start[0] = 1'b1;
    ops[0]   = 8'h35;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    chk("pre_rst_sn", sn[0], 1);
    chk("pre_rst_z", z[0], 13);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_z", z[0], 0);
    chk("mid_rst_sn", sn[0], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(0, 8'h72, 256, 14, 0, 1'b0, 1'b0, "post_rst_2x7");

    // Back-to-back: start held through done, second run accepted on the first IDLE cycle
    run(1, 8'h35, 48, 15, 0, 1'b0, 1'b1, "b2b_first");
    run(1, 8'h27, 32, 14, 0, 1'b0, 1'b0, "b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
